// File: rtl/iob_reg_pipe_pkg.sv
// Shared definitions for the iob_reg_pipe_vr register pipeline: the width helper for the
// optional occupancy output, and the per-stage reset/enable/flush priority decode.
package iob_reg_pipe_pkg;

  // Action a stage takes on the next rising edge, listed from highest priority to lowest.
  typedef enum logic [1:0] {
    STG_RESET = 2'd0,
    STG_HOLD  = 2'd1,
    STG_CLEAR = 2'd2,
    STG_LOAD  = 2'd3
  } stg_op_e;

  // Width of a counter that can hold every value from 0 to depth.
  function automatic int level_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Order of precedence: reset, then clock-enable gating, then flush, then the normal load.
  function automatic stg_op_e stage_op(input logic rst, input logic cke, input logic flush,
                                       input logic load);
    if (rst)        return STG_RESET;
    else if (!cke)  return STG_HOLD;
    else if (flush) return STG_CLEAR;
    else if (load)  return STG_LOAD;
    else            return STG_HOLD;
  endfunction

endpackage

// File: rtl/iob_reg_pipe_stage.sv
// One pipeline stage: a valid bit plus a data register. The data register loads only
// when the incoming word is valid, so a bubble passing through causes no data toggling.
module iob_reg_pipe_stage
  import iob_reg_pipe_pkg::*;
#(
  parameter int                 DATA_W  = 8,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  stg_op_e           op;

  assign op = stage_op(rst_i, cke_i, clr_i, load_i);

  // NOTE: state registers use non-blocking assignments so every stage samples its
  // upstream neighbour's pre-edge value and the word advances exactly one stage per edge.
  always_ff @(posedge clk_i) begin
    case (op)
      STG_RESET: begin
        valid_q <= 1'b0;
        data_q  <= RST_VAL;
      end
      STG_CLEAR: valid_q <= 1'b0;
      STG_LOAD: begin
        valid_q <= valid_i;
        if (valid_i) data_q <= data_i;
      end
      default: ;
    endcase
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/iob_reg_pipe_vr.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse and synchronous flush.
// Define IOB_REG_PIPE_LEVEL_EN to add the registered occupancy output level_o.
module iob_reg_pipe_vr
  import iob_reg_pipe_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                DEPTH   = 2,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int               LEVEL_W = level_w(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cke_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i
`ifdef IOB_REG_PIPE_LEVEL_EN
  ,
  output logic [LEVEL_W-1:0] level_o
`endif
);

  logic [DEPTH-1:0] stage_vld;
  logic [DEPTH-1:0] stage_rdy;
  logic [DATA_W-1:0] stage_dat [DEPTH];

  // A stage can load when it is empty or when everything downstream of it is moving.
  always_comb begin
    stage_rdy = '0;
    stage_rdy[DEPTH-1] = !stage_vld[DEPTH-1] || out_ready_i;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      stage_rdy[k] = !stage_vld[k] || stage_rdy[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              src_vld;
    logic [DATA_W-1:0] src_dat;

    if (k == 0) begin : g_head
      assign src_vld = in_valid_i;
      assign src_dat = in_data_i;
    end else begin : g_body
      assign src_vld = stage_vld[k-1];
      assign src_dat = stage_dat[k-1];
    end

    iob_reg_pipe_stage #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cke_i   (cke_i),
      .clr_i   (flush_i),
      .load_i  (stage_rdy[k]),
      .valid_i (src_vld),
      .data_i  (src_dat),
      .valid_o (stage_vld[k]),
      .data_o  (stage_dat[k])
    );
  end

  assign in_ready_o  = stage_rdy[0] && !flush_i && cke_i;
  assign out_valid_o = stage_vld[DEPTH-1];
  assign out_data_o  = stage_dat[DEPTH-1];

`ifdef IOB_REG_PIPE_LEVEL_EN
  logic               in_xfer;
  logic               out_xfer;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;

  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_o && out_ready_i && cke_i;

  always_comb begin
    level_d = level_q;
    case ({in_xfer, out_xfer})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    case (stage_op(rst_i, cke_i, flush_i, 1'b1))
      STG_RESET, STG_CLEAR: level_q <= '0;
      STG_LOAD:             level_q <= level_d;
      default: ;
    endcase
  end

  assign level_o = level_q;
`endif

endmodule
